// File: rtl/uart_pkt_deframer.sv
//------------------------------------------------------------------------------
// Module  : uart_pkt_deframer
// Brief   : Pops bytes from a uart rx path, validates SOF/LEN/payload/CHK
//           frames and forwards good payloads on a valid/ready byte stream.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_pkt_deframer #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       parity_err,
  output logic       rx_req,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_req_q;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    buf_q [MAX_LEN];

  logic          w_in_frame;
  logic          w_tmo_hit;
  logic          w_buf_we;
  logic [7:0]    w_len_m1;

  assign w_in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
  assign w_len_m1   = len_q - 8'd1;

  // The delayed strobe guarantees the uart has a cycle to advance its data.
  assign rx_req    = rx_ready & (state_q != S_SEND) & ~rx_req_q;
  assign pkt_valid = (state_q == S_SEND);
  assign pkt_data  = pkt_valid ? buf_q[rd_idx_q[AW-1:0]] : 8'd0;
  assign pkt_last  = pkt_valid && (rd_idx_q == w_len_m1);
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    chk_d       = chk_q;
    tmo_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    w_buf_we    = 1'b0;

    if (w_in_frame) begin
      tmo_d = rx_req ? '0 : tmo_q + TW'(1);
    end

    if (w_in_frame && rx_req && parity_err) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = S_IDLE;
    end else if (w_in_frame && !rx_req && w_tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd2;
      state_d     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_req && !parity_err && (rx_data == SOF_BYTE)) begin
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (rx_req) begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd0;
              state_d     = S_IDLE;
            end else begin
              len_d   = rx_data;
              chk_d   = rx_data;
              idx_d   = 8'd0;
              state_d = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_req) begin
            w_buf_we = 1'b1;
            chk_d    = chk_q ^ rx_data;
            idx_d    = idx_q + 8'd1;
            if (idx_q == w_len_m1) begin
              state_d = S_CHK;
            end
          end
        end
        S_CHK: begin
          if (rx_req) begin
            if (rx_data == chk_q) begin
              frame_ok_d = 1'b1;
              rd_idx_d   = 8'd0;
              state_d    = S_SEND;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd1;
              state_d     = S_IDLE;
            end
          end
        end
        S_SEND: begin
          if (pkt_ready) begin
            if (rd_idx_q == w_len_m1) begin
              state_d = S_IDLE;
            end else begin
              rd_idx_d = rd_idx_q + 8'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_req_q    <= 1'b0;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      rd_idx_q    <= 8'd0;
      chk_q       <= 8'd0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      rx_req_q    <= rx_req;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload storage is only read in SEND, after being fully written.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      buf_q[idx_q[AW-1:0]] <= rx_data;
    end
  end

endmodule

`default_nettype wire
